// File: rtl/alu_sequencer_pkg.sv
// alu_sequencer_pkg
// Shared CPU definitions for the ALU issue path:
//   - op_t      : abstract opcodes presented by the control unit
//   - ALU_*     : 3-bit control codes understood by the registered ALU
//   - state_t   : sequencer FSM states (also visible on the debug port)
package alu_sequencer_pkg;

  localparam int DATA_W = 32;
  localparam int CTRL_W = 3;

  typedef enum logic [2:0] {
    OP_AND = 3'd0,
    OP_OR  = 3'd1,
    OP_ADD = 3'd2,
    OP_SUB = 3'd3,
    OP_MUL = 3'd4
  } op_t;

  localparam logic [CTRL_W-1:0] ALU_AND = 3'b000;
  localparam logic [CTRL_W-1:0] ALU_OR  = 3'b001;
  localparam logic [CTRL_W-1:0] ALU_ADD = 3'b010;
  localparam logic [CTRL_W-1:0] ALU_SUB = 3'b110;
  localparam logic [CTRL_W-1:0] ALU_MUL = 3'b111;

  typedef enum logic [2:0] {
    ST_IDLE    = 3'd0,
    ST_ISSUE   = 3'd1,
    ST_SETTLE  = 3'd2,
    ST_CAPTURE = 3'd3,
    ST_RESP    = 3'd4
  } state_t;

endpackage

// File: rtl/alu_op_decode.sv
// alu_op_decode
// Combinational map from abstract opcode to ALU control code.
// Ports:
//   i_op       in  3  abstract opcode (0..4 legal, 5..7 illegal)
//   o_control  out 3  ALU control code (ALU_AND when illegal; never driven then)
//   o_illegal  out 1  opcode has no ALU mapping
module alu_op_decode
  import alu_sequencer_pkg::*;
(
  input  logic [2:0] i_op,
  output logic [2:0] o_control,
  output logic       o_illegal
);

  always_comb begin
    o_control = ALU_AND;
    o_illegal = 1'b0;
    case (i_op)
      OP_AND:  o_control = ALU_AND;
      OP_OR:   o_control = ALU_OR;
      OP_ADD:  o_control = ALU_ADD;
      OP_SUB:  o_control = ALU_SUB;
      OP_MUL:  o_control = ALU_MUL;
      default: o_illegal = 1'b1;
    endcase
  end

endmodule

// File: rtl/alu_sequencer.sv
// alu_sequencer
// Issue controller in front of the registered ALU. Accepts one request at a
// time, drives and holds the ALU operands until the registered result and the
// one-cycle-later zero flag have settled, then returns them as a response.
//
// Handshakes: a transfer happens on a rising edge where valid and ready are
// both 1. Once valid is raised it stays up, with its payload stable, until that
// edge. The sequencer raises o_req_ready only in IDLE, and holds o_resp_valid
// and all o_resp_* fields stable in RESP until i_resp_ready is seen.
//
// Ports:
//   clk, rst_n          clock, asynchronous active-low reset
//   i_req_valid/o_req_ready, i_req_op, i_req_a, i_req_b   request channel
//   o_alu_a, o_alu_b, o_alu_control                       ALU operand side
//   i_alu_result, i_alu_zero                              ALU outputs
//   o_resp_valid/i_resp_ready, o_resp_result, o_resp_zero, o_resp_err
//   o_dbg_state         current FSM state (state_t encoding)
module alu_sequencer
  import alu_sequencer_pkg::*;
(
  input  logic        clk,
  input  logic        rst_n,
  input  logic        i_req_valid,
  output logic        o_req_ready,
  input  logic [2:0]  i_req_op,
  input  logic [31:0] i_req_a,
  input  logic [31:0] i_req_b,
  output logic [31:0] o_alu_a,
  output logic [31:0] o_alu_b,
  output logic [2:0]  o_alu_control,
  input  logic [31:0] i_alu_result,
  input  logic        i_alu_zero,
  output logic        o_resp_valid,
  input  logic        i_resp_ready,
  output logic [31:0] o_resp_result,
  output logic        o_resp_zero,
  output logic        o_resp_err,
  output logic [2:0]  o_dbg_state
);

  state_t      r_state;
  logic        r_req_ready;
  logic        r_resp_valid;
  logic [31:0] r_resp_result;
  logic        r_resp_zero;
  logic        r_resp_err;
  logic [31:0] r_alu_a;
  logic [31:0] r_alu_b;
  logic [2:0]  r_alu_control;

  logic [2:0]  w_control;
  logic        w_illegal;

  alu_op_decode u_decode (
    .i_op      (i_req_op),
    .o_control (w_control),
    .o_illegal (w_illegal)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state       <= ST_IDLE;
      r_req_ready   <= 1'b1;
      r_resp_valid  <= 1'b0;
      r_resp_result <= '0;
      r_resp_zero   <= 1'b0;
      r_resp_err    <= 1'b0;
      r_alu_a       <= '0;
      r_alu_b       <= '0;
      r_alu_control <= ALU_AND;
    end else begin
      case (r_state)
        ST_IDLE: begin
          if (i_req_valid) begin
            r_req_ready <= 1'b0;
            if (w_illegal) begin
              // Illegal ops never touch the ALU; answer directly.
              r_resp_result <= '0;
              r_resp_zero   <= 1'b0;
              r_resp_err    <= 1'b1;
              r_resp_valid  <= 1'b1;
              r_state       <= ST_RESP;
            end else begin
              r_alu_a       <= i_req_a;
              r_alu_b       <= i_req_b;
              r_alu_control <= w_control;
              r_state       <= ST_ISSUE;
            end
          end
        end
        // ISSUE: ALU samples operands. SETTLE: alu_zero catches up with the
        // new result. Operands are held so the ALU keeps resampling the same
        // inputs and alu_result is still correct when CAPTURE reads it.
        ST_ISSUE:  r_state <= ST_SETTLE;
        ST_SETTLE: r_state <= ST_CAPTURE;
        ST_CAPTURE: begin
          r_resp_result <= i_alu_result;
          r_resp_zero   <= i_alu_zero;
          r_resp_err    <= 1'b0;
          r_resp_valid  <= 1'b1;
          r_state       <= ST_RESP;
        end
        ST_RESP: begin
          if (i_resp_ready) begin
            // Ready rises only after this edge, so no request can be
            // accepted on the edge that completes the response.
            r_resp_valid <= 1'b0;
            r_req_ready  <= 1'b1;
            r_state      <= ST_IDLE;
          end
        end
        default: begin
          r_resp_valid <= 1'b0;
          r_req_ready  <= 1'b1;
          r_state      <= ST_IDLE;
        end
      endcase
    end
  end

  assign o_req_ready   = r_req_ready;
  assign o_resp_valid  = r_resp_valid;
  assign o_resp_result = r_resp_result;
  assign o_resp_zero   = r_resp_zero;
  assign o_resp_err    = r_resp_err;
  assign o_alu_a       = r_alu_a;
  assign o_alu_b       = r_alu_b;
  assign o_alu_control = r_alu_control;
  assign o_dbg_state   = r_state;

endmodule

// File: tb/tb_alu_sequencer.sv
module tb_alu_sequencer;
  import alu_sequencer_pkg::*;

  // ---------------- clock / reset ----------------
  logic clk;
  logic rst_n;
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // ---------------- DUT signals ----------------
  logic        i_req_valid;
  logic        o_req_ready;
  logic [2:0]  i_req_op;
  logic [31:0] i_req_a;
  logic [31:0] i_req_b;
  logic [31:0] o_alu_a;
  logic [31:0] o_alu_b;
  logic [2:0]  o_alu_control;
  logic [31:0] alu_result;
  logic        alu_zero;
  logic        o_resp_valid;
  logic        i_resp_ready;
  logic [31:0] o_resp_result;
  logic        o_resp_zero;
  logic        o_resp_err;
  logic [2:0]  o_dbg_state;

  alu_sequencer dut (
    .clk           (clk),
    .rst_n         (rst_n),
    .i_req_valid   (i_req_valid),
    .o_req_ready   (o_req_ready),
    .i_req_op      (i_req_op),
    .i_req_a       (i_req_a),
    .i_req_b       (i_req_b),
    .o_alu_a       (o_alu_a),
    .o_alu_b       (o_alu_b),
    .o_alu_control (o_alu_control),
    .i_alu_result  (alu_result),
    .i_alu_zero    (alu_zero),
    .o_resp_valid  (o_resp_valid),
    .i_resp_ready  (i_resp_ready),
    .o_resp_result (o_resp_result),
    .o_resp_zero   (o_resp_zero),
    .o_resp_err    (o_resp_err),
    .o_dbg_state   (o_dbg_state)
  );

  // ---------------- registered ALU ----------------
  // Result registered on each edge; zero flag registered one edge later.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      alu_result <= '0;
      alu_zero   <= 1'b0;
    end else begin
      case (o_alu_control)
        3'b000:  alu_result <= o_alu_a & o_alu_b;
        3'b001:  alu_result <= o_alu_a | o_alu_b;
        3'b010:  alu_result <= o_alu_a + o_alu_b;
        3'b110:  alu_result <= o_alu_a - o_alu_b;
        3'b111:  alu_result <= o_alu_a * o_alu_b;
        default: alu_result <= '0;
      endcase
      alu_zero <= (alu_result == 32'd0);
    end
  end

  // ---------------- scoreboard ----------------
  int checks = 0;
  int failures = 0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  // ---------------- driver tasks ----------------
  // All driving and sampling happens 1ns after a rising edge.
  task automatic send(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b);
    int n;
    n = 0;
    i_req_op    = op;
    i_req_a     = a;
    i_req_b     = b;
    i_req_valid = 1'b1;
    while (!o_req_ready && n < 50) begin
      @(posedge clk); #1;
      n++;
    end
    check("req_ready_before_accept", 32'(o_req_ready), 32'd1);
    @(posedge clk); #1;
    i_req_valid = 1'b0;
  endtask

  // Latency is the number of edges from the accept edge up to and including
  // the first edge at which resp_valid is sampled high.
  task automatic wait_resp(output int lat);
    lat = 0;
    while (!o_resp_valid && lat < 50) begin
      @(posedge clk); #1;
      lat++;
    end
    lat = lat + 1;
    check("resp_valid_seen", 32'(o_resp_valid), 32'd1);
  endtask

  task automatic complete_resp();
    i_resp_ready = 1'b1;
    @(posedge clk); #1;
    i_resp_ready = 1'b0;
    check("resp_valid_drop", 32'(o_resp_valid), 32'd0);
    check("req_ready_back", 32'(o_req_ready), 32'd1);
  endtask

  task automatic do_op(input string tag, input logic [2:0] op,
                       input logic [31:0] a, input logic [31:0] b,
                       input logic [31:0] exp_res, input logic exp_zero,
                       input logic exp_err, input int exp_lat,
                       input logic [31:0] exp_alu_a, input logic [31:0] exp_alu_b,
                       input logic [2:0] exp_ctrl);
    int lat;
    send(op, a, b);
    wait_resp(lat);
    check({tag, "_latency"}, 32'(lat), 32'(exp_lat));
    check({tag, "_result"}, o_resp_result, exp_res);
    check({tag, "_zero"}, 32'(o_resp_zero), 32'(exp_zero));
    check({tag, "_err"}, 32'(o_resp_err), 32'(exp_err));
    check({tag, "_req_ready_low"}, 32'(o_req_ready), 32'd0);
    check({tag, "_alu_a"}, o_alu_a, exp_alu_a);
    check({tag, "_alu_b"}, o_alu_b, exp_alu_b);
    check({tag, "_alu_ctrl"}, 32'(o_alu_control), 32'(exp_ctrl));
    complete_resp();
  endtask

  task automatic check_reset_values(input string tag);
    check({tag, "_req_ready"}, 32'(o_req_ready), 32'd1);
    check({tag, "_resp_valid"}, 32'(o_resp_valid), 32'd0);
    check({tag, "_resp_result"}, o_resp_result, 32'd0);
    check({tag, "_resp_zero"}, 32'(o_resp_zero), 32'd0);
    check({tag, "_resp_err"}, 32'(o_resp_err), 32'd0);
    check({tag, "_alu_a"}, o_alu_a, 32'd0);
    check({tag, "_alu_b"}, o_alu_b, 32'd0);
    check({tag, "_alu_ctrl"}, 32'(o_alu_control), 32'd0);
    check({tag, "_state"}, 32'(o_dbg_state), 32'd0);
  endtask

  // ---------------- directed sequence ----------------
  initial begin
    int n;
    rst_n        = 1'b0;
    i_req_valid  = 1'b0;
    i_req_op     = 3'd0;
    i_req_a      = 32'd0;
    i_req_b      = 32'd0;
    i_resp_ready = 1'b0;

    // Reset state
    #12;
    check_reset_values("in_reset");
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk); #1;
    check_reset_values("after_reset");

    // Legal ops: op, a, b, result, zero, err, latency, alu a/b/ctrl
    do_op("add_5_7",   3'd2, 32'd5, 32'd7, 32'd12, 1'b0, 1'b0, 4, 32'd5, 32'd7, 3'b010);
    do_op("sub_9_9",   3'd3, 32'd9, 32'd9, 32'd0, 1'b1, 1'b0, 4, 32'd9, 32'd9, 3'b110);
    // Zero flag from the previous op (1) must not leak into this one.
    do_op("sub_0_1",   3'd3, 32'd0, 32'd1, 32'hFFFF_FFFF, 1'b0, 1'b0, 4, 32'd0, 32'd1, 3'b110);
    do_op("mul_wrap",  3'd4, 32'h0001_0000, 32'h0001_0000, 32'd0, 1'b1, 1'b0, 4,
          32'h0001_0000, 32'h0001_0000, 3'b111);
    do_op("and",       3'd0, 32'h0000_F0F0, 32'h0000_0FF0, 32'h0000_00F0, 1'b0, 1'b0, 4,
          32'h0000_F0F0, 32'h0000_0FF0, 3'b000);
    do_op("or",        3'd1, 32'h0000_F000, 32'h0000_000F, 32'h0000_F00F, 1'b0, 1'b0, 4,
          32'h0000_F000, 32'h0000_000F, 3'b001);

    // Illegal ops: ALU outputs keep the OR operands
    do_op("illegal6",  3'd6, 32'hDEAD_BEEF, 32'h1234_5678, 32'd0, 1'b0, 1'b1, 1,
          32'h0000_F000, 32'h0000_000F, 3'b001);
    do_op("illegal7",  3'd7, 32'hAAAA_AAAA, 32'h5555_5555, 32'd0, 1'b0, 1'b1, 1,
          32'h0000_F000, 32'h0000_000F, 3'b001);
    // Legal op right after illegal ones clears err
    do_op("mul_3_5",   3'd4, 32'd3, 32'd5, 32'd15, 1'b0, 1'b0, 4, 32'd3, 32'd5, 3'b111);

    // Backpressure: ADD 1+1 with resp_ready low for 10 cycles
    send(3'd2, 32'd1, 32'd1);
    wait_resp(n);
    check("bp_latency", 32'(n), 32'd4);
    for (int i = 0; i < 10; i++) begin
      @(posedge clk); #1;
      check("bp_valid_held", 32'(o_resp_valid), 32'd1);
      check("bp_result_held", o_resp_result, 32'd2);
      check("bp_zero_held", 32'(o_resp_zero), 32'd0);
      check("bp_err_held", 32'(o_resp_err), 32'd0);
      check("bp_req_ready_low", 32'(o_req_ready), 32'd0);
    end
    // Next request presented together with resp_ready: not accepted on the
    // completing edge, accepted one edge later.
    i_req_op     = 3'd2;
    i_req_a      = 32'd2;
    i_req_b      = 32'd3;
    i_req_valid  = 1'b1;
    i_resp_ready = 1'b1;
    @(posedge clk); #1;
    i_resp_ready = 1'b0;
    check("bp_done_state_idle", 32'(o_dbg_state), 32'(ST_IDLE));
    check("bp_done_valid_low", 32'(o_resp_valid), 32'd0);
    check("bp_done_req_ready", 32'(o_req_ready), 32'd1);
    @(posedge clk); #1;
    i_req_valid = 1'b0;
    check("bp_next_accepted", 32'(o_dbg_state), 32'(ST_ISSUE));
    wait_resp(n);
    check("bp_next_latency", 32'(n), 32'd4);
    check("bp_next_result", o_resp_result, 32'd5);
    complete_resp();

    // Throughput with resp_ready held high: 5 cycles per legal op
    i_req_op     = 3'd2;
    i_req_a      = 32'd1;
    i_req_b      = 32'd2;
    i_resp_ready = 1'b1;
    i_req_valid  = 1'b1;
    n = 0;
    do begin
      @(posedge clk); #1;
      n++;
    end while (o_dbg_state != ST_ISSUE && n < 20);
    check("tp_first_issue", 32'(o_dbg_state), 32'(ST_ISSUE));
    n = 0;
    do begin
      @(posedge clk); #1;
      n++;
    end while (o_dbg_state != ST_ISSUE && n < 20);
    check("tp_cycles_per_op", 32'(n), 32'd5);
    i_req_valid = 1'b0;
    n = 0;
    while (o_dbg_state != ST_IDLE && n < 20) begin
      @(posedge clk); #1;
      n++;
    end
    i_resp_ready = 1'b0;
    check("tp_back_idle", 32'(o_dbg_state), 32'(ST_IDLE));
    check("tp_last_result", o_resp_result, 32'd3);

    // Reset during SETTLE aborts with no response
    send(3'd2, 32'd10, 32'd20);
    @(posedge clk); #1;
    check("rst_in_settle", 32'(o_dbg_state), 32'(ST_SETTLE));
    rst_n = 1'b0;
    #1;
    check_reset_values("mid_reset");
    @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    for (int i = 0; i < 6; i++) begin
      @(posedge clk); #1;
      check("post_reset_no_resp", 32'(o_resp_valid), 32'd0);
    end
    check("post_reset_idle", 32'(o_dbg_state), 32'(ST_IDLE));
    do_op("add_3_4",   3'd2, 32'd3, 32'd4, 32'd7, 1'b0, 1'b0, 4, 32'd3, 32'd4, 3'b010);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  // Global watchdog
  initial begin
    #200000;
    $display("FAIL watchdog timeout observed=running expected=finished");
    $fatal(1, "watchdog");
  end

endmodule
